and_merge_scheduler: RTL and testbench

- Round-robin scheduler that shares one two-stage AND-merge datapath among NREQ requesters.
- Stage 1 holds an operand capture pair (a, b); stage 2 holds a result register (a & b).
- Each accepted request produces one tagged result.
- Sits between independent launch domains (already synchronised to clk) and a single downstream consumer with backpressure.

---
 rtl/and_merge_scheduler_pkg.sv | 20 ++
 rtl/and_merge_scheduler_rr_arbiter.sv | 33 +++
 rtl/and_merge_scheduler.sv | 115 +++++++++++
 tb/tb_and_merge_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/and_merge_scheduler_pkg.sv
// Shared types for the AND-merge scheduler family: FSM state encoding and
// requester-tag width derivation.
package and_merge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Stage records are built from these field widths by the user module,
    // since packed struct fields cannot take module parameters directly.
    localparam int STAGE_VALID_W = 1;

endpackage

// File: rtl/and_merge_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or above
// ptr, wrapping modulo NREQ, wins.
module rr_arbiter
    import and_merge_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int ID_W = calc_id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = (int'(ptr) + k) % NREQ;
            if (!w_found && req[w_j]) begin
                w_found     = 1'b1;
                grant[w_j]  = 1'b1;
                idx         = ID_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/and_merge_scheduler.sv
// Round-robin scheduler feeding NREQ requesters into one shared two-stage
// AND-merge pipeline with a backpressured, tagged result port.
module and_merge_scheduler
    import and_merge_pkg::*;
#(
    parameter  int NREQ  = 2,
    parameter  int WIDTH = 8,
    localparam int ID_W  = calc_id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  busy
);

    typedef struct packed {
        logic [STAGE_VALID_W-1:0] valid;
        logic [WIDTH-1:0]         a;
        logic [WIDTH-1:0]         b;
        logic [ID_W-1:0]          id;
    } s1_t;

    typedef struct packed {
        logic [STAGE_VALID_W-1:0] valid;
        logic [WIDTH-1:0]         data;
        logic [ID_W-1:0]          id;
    } s2_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ID_W-1:0] r_ptr;
    s1_t             r_s1;
    s2_t             r_s2;

    logic [NREQ-1:0] w_grant;
    logic [ID_W-1:0] w_idx;
    logic [ID_W-1:0] w_ptr_nxt;
    logic            w_s2_adv;
    logic            w_s1_adv;
    logic            w_accept;
    logic            w_empty;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .idx   (w_idx)
    );

    assign w_s2_adv  = !r_s2.valid[0] || out_ready;
    assign w_s1_adv  = !r_s1.valid[0] || w_s2_adv;
    assign w_empty   = !r_s1.valid[0] && !r_s2.valid[0];
    assign req_ready = (w_s1_adv && (r_state == RUN)) ? w_grant : '0;
    assign w_accept  = |req_ready;
    assign w_ptr_nxt = (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + ID_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en) w_state_nxt = RUN;
            RUN:     if (!en) w_state_nxt = w_empty ? IDLE : DRAIN;
            // Re-enable takes priority over finishing the drain.
            DRAIN: begin
                if (en)           w_state_nxt = RUN;
                else if (w_empty) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_ptr <= w_ptr_nxt;

            if (w_s1_adv) begin
                r_s1.valid <= w_accept;
                if (w_accept) begin
                    r_s1.a  <= req_a[w_idx*WIDTH +: WIDTH];
                    r_s1.b  <= req_b[w_idx*WIDTH +: WIDTH];
                    r_s1.id <= w_idx;
                end
            end

            // Stage 2 only moves when empty or consumed, so the result
            // stays stable while the consumer stalls.
            if (w_s2_adv) begin
                r_s2.valid <= r_s1.valid;
                if (r_s1.valid[0]) begin
                    r_s2.data <= r_s1.a & r_s1.b;
                    r_s2.id   <= r_s1.id;
                end
            end
        end
    end

    assign out_valid = r_s2.valid[0];
    assign out_data  = r_s2.data;
    assign out_id    = r_s2.id;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_and_merge_scheduler.sv
// Self-checking bench for and_merge_scheduler with a slot-level reference
// model and an accept-order scoreboard.
module tb_and_merge_scheduler;

    localparam int NREQ  = 2;
    localparam int WIDTH = 8;
    localparam int ID_W  = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [ID_W-1:0]       out_id;
    logic                  busy;

    always #5 clk = ~clk;

    and_merge_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: mode 0 idle, 1 run, 2 drain; two result slots.
    int               m_state = 0;
    int               m_ptr   = 0;
    bit               m_s1v   = 0;
    bit               m_s2v   = 0;
    logic [WIDTH-1:0] m_s1d   = '0;
    logic [WIDTH-1:0] m_s2d   = '0;
    int               m_s1id  = 0;
    int               m_s2id  = 0;
    int               m_win;
    bit               m_acc;
    logic [NREQ-1:0]  exp_ready;
    bit               exp_busy;
    logic [NREQ-1:0]  rdy_seen;

    int exp_q[$];
    int got_q[$];

    function automatic logic [WIDTH-1:0] opa(input int i);
        return req_a[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [WIDTH-1:0] opb(input int i);
        return req_b[i*WIDTH +: WIDTH];
    endfunction

    function automatic void model_eval();
        logic [NREQ-1:0] one;
        bit s2adv, s1adv;
        one   = 1;
        m_win = -1;
        for (int k = 0; k < NREQ; k++)
            if (m_win < 0 && req_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
        s2adv     = !m_s2v || out_ready;
        s1adv     = !m_s1v || s2adv;
        m_acc     = (m_state == 1) && (m_win >= 0) && s1adv;
        exp_ready = m_acc ? (one << m_win) : '0;
        exp_busy  = (m_state != 0);
    endfunction

    task automatic raise(input int i);
        req_valid[i]              = 1'b1;
        req_a[i*WIDTH +: WIDTH]   = WIDTH'($urandom);
        req_b[i*WIDTH +: WIDTH]   = WIDTH'($urandom);
    endtask

    task automatic refill();
        for (int i = 0; i < NREQ; i++) if (!req_valid[i]) raise(i);
    endtask

    // Advances model and clock by one cycle; upstream drops accepted requests.
    task automatic adv();
        bit s2adv, s1adv, empty;
        model_eval();
        rdy_seen = req_ready;
        if (rst) begin
            m_state = 0; m_ptr = 0; m_s1v = 0; m_s2v = 0;
            m_s1d = '0; m_s2d = '0; m_s1id = 0; m_s2id = 0;
            exp_q.delete();
            got_q.delete();
        end else begin
            if (out_valid === 1'b1 && out_ready) got_q.push_back(int'(out_id) * 256 + int'(out_data));
            s2adv = !m_s2v || out_ready;
            s1adv = !m_s1v || s2adv;
            empty = !m_s1v && !m_s2v;
            if (m_acc) exp_q.push_back(m_win * 256 + int'(opa(m_win) & opb(m_win)));
            if (s2adv) begin
                if (m_s1v) begin m_s2d = m_s1d; m_s2id = m_s1id; end
                m_s2v = m_s1v;
            end
            if (s1adv) begin
                m_s1v = m_acc;
                if (m_acc) begin m_s1d = opa(m_win) & opb(m_win); m_s1id = m_win; end
            end
            if (m_acc) m_ptr = (m_win + 1) % NREQ;
            case (m_state)
                0: if (en) m_state = 1;
                1: if (!en) m_state = empty ? 0 : 2;
                default: if (en) m_state = 1; else if (empty) m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) if (rdy_seen[i] && req_valid[i]) req_valid[i] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; out_ready = 1; req_valid = 2'b11;
        req_a = '0; req_b = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++;
                if (out_valid !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state ov=%b rdy=%b busy=%b, want 0/00/0", out_valid, req_ready, busy);
                end
            end
            adv();
        end
        rst = 0; en = 1; req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy busy=%b want 0", busy); end
        adv();
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL run_busy busy=%b want 1", busy); end
        adv();
    endtask

    task automatic test_single();
        int  acc_cyc = -1;
        bit  done    = 0;
        out_ready = 1; en = 1;
        req_valid = 2'b01; req_a[7:0] = 8'hF0; req_b[7:0] = 8'h3C;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (req_ready !== exp_ready || out_valid !== m_s2v || out_data !== m_s2d ||
                out_id !== ID_W'(m_s2id) || busy !== exp_busy) begin
                errors++;
                $display("FAIL single_model cyc=%0d rdy=%b/%b ov=%b/%b d=%h/%h id=%0d/%0d", cyc,
                         req_ready, exp_ready, out_valid, m_s2v, out_data, m_s2d, out_id, m_s2id);
            end
            if (acc_cyc >= 0 && cyc == acc_cyc + 1) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early ov=%b want 0", out_valid); end
            end
            if (acc_cyc >= 0 && cyc == acc_cyc + 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'h30 || out_id !== 1'b0) begin
                    errors++;
                    $display("FAIL single_result ov=%b d=%h id=%0d, want 1/30/0", out_valid, out_data, out_id);
                end
                done = 1;
            end
            if (acc_cyc < 0 && m_acc && m_win == 0) acc_cyc = cyc;
            adv();
        end
        if (!done) begin checks++; errors++; $display("FAIL single_timeout no result within 10 cycles"); end
    endtask

    task automatic test_rr();
        int order[$];
        int cycs[$];
        rst = 1; en = 1; req_valid = '0;
        adv();
        rst = 0; refill();
        for (int i = 0; i < 20 && order.size() < 6; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (req_ready !== exp_ready || out_valid !== m_s2v || out_data !== m_s2d ||
                out_id !== ID_W'(m_s2id) || busy !== exp_busy) begin
                errors++;
                $display("FAIL rr_model cyc=%0d rdy=%b/%b ov=%b/%b d=%h/%h id=%0d/%0d", cyc,
                         req_ready, exp_ready, out_valid, m_s2v, out_data, m_s2d, out_id, m_s2id);
            end
            for (int k = 0; k < NREQ; k++)
                if (req_ready[k] && req_valid[k]) begin order.push_back(k); cycs.push_back(cyc); end
            adv();
            refill();
        end
        checks++;
        if (order.size() != 6) begin
            errors++; $display("FAIL rr_count accepts=%0d want 6", order.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (order[k] != k % 2) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, order[k], k % 2); end
            end
            checks++;
            if (cycs[5] - cycs[0] != 5) begin errors++; $display("FAIL rr_rate span=%0d want 5", cycs[5] - cycs[0]); end
        end
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); adv(); end
        checks++;
        if (got_q.size() != 6) begin errors++; $display("FAIL rr_results got %0d want 6", got_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL rr_sb[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_backpressure();
        int nacc   = 0;
        int stall  = -1;
        int first  = -1;
        req_valid = '0; out_ready = 1; en = 1;
        for (int i = 0; i < 3; i++) begin @(negedge clk); adv(); end
        out_ready = 0; refill();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (req_ready !== exp_ready || out_valid !== m_s2v || out_data !== m_s2d ||
                out_id !== ID_W'(m_s2id) || busy !== exp_busy) begin
                errors++;
                $display("FAIL bp_model cyc=%0d rdy=%b/%b ov=%b/%b d=%h/%h id=%0d/%0d", cyc,
                         req_ready, exp_ready, out_valid, m_s2v, out_data, m_s2d, out_id, m_s2id);
            end
            if (|(req_ready & req_valid)) nacc++;
            if (i == 4) begin
                stall = m_win;
                checks++;
                if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_stall_ready rdy=%b want 00", req_ready); end
            end
            adv();
            refill();
        end
        checks++;
        if (nacc != 2) begin errors++; $display("FAIL bp_held accepts=%0d want 2", nacc); end
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (req_ready !== exp_ready || out_valid !== m_s2v || out_data !== m_s2d ||
                out_id !== ID_W'(m_s2id) || busy !== exp_busy) begin
                errors++;
                $display("FAIL bp_release cyc=%0d rdy=%b/%b ov=%b/%b d=%h/%h id=%0d/%0d", cyc,
                         req_ready, exp_ready, out_valid, m_s2v, out_data, m_s2d, out_id, m_s2id);
            end
            for (int k = 0; k < NREQ; k++) if (first < 0 && req_ready[k] && req_valid[k]) first = k;
            adv();
        end
        checks++;
        if (first != stall) begin errors++; $display("FAIL bp_priority first=%0d want %0d", first, stall); end
        checks++;
        if (got_q.size() > exp_q.size()) begin errors++; $display("FAIL bp_sb_size got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL bp_sb[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_drain();
        int first_acc = 0;
        int late_acc  = 0;
        int last_hs   = -1;
        int idle_cyc  = -1;
        en = 1; out_ready = 0; refill();
        for (int i = 0; i < 6 && !(m_s1v && m_s2v); i++) begin @(negedge clk); adv(); refill(); end
        en = 0; out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            model_eval();
            checks++;
            if (req_ready !== exp_ready || out_valid !== m_s2v || out_data !== m_s2d ||
                out_id !== ID_W'(m_s2id) || busy !== exp_busy) begin
                errors++;
                $display("FAIL drain_model cyc=%0d rdy=%b/%b ov=%b/%b busy=%b/%b", cyc,
                         req_ready, exp_ready, out_valid, m_s2v, busy, exp_busy);
            end
            if (i == 0 && |req_ready) first_acc++;
            if (i > 0 && |req_ready) late_acc++;
            if (out_valid === 1'b1) last_hs = cyc;
            if (idle_cyc < 0 && busy === 1'b0) idle_cyc = cyc;
            adv();
            refill();
        end
        // The accept in the same cycle as en falls is still taken.
        checks++;
        if (first_acc != 1) begin errors++; $display("FAIL drain_edge_accept got %0d want 1", first_acc); end
        checks++;
        if (late_acc != 0) begin errors++; $display("FAIL drain_no_accept got %0d want 0", late_acc); end
        // Last handshake cycle, then one DRAIN cycle seeing an empty pipe, then IDLE.
        checks++;
        if (idle_cyc - last_hs != 2) begin errors++; $display("FAIL drain_busy_fall gap=%0d want 2", idle_cyc - last_hs); end
        checks++;
        if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL drain_sb_size got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL drain_sb[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        en = 1; out_ready = 0; refill();
        for (int i = 0; i < 8 && !(m_s1v && m_s2v); i++) begin @(negedge clk); adv(); refill(); end
        rst = 1;
        @(negedge clk);
        adv();
        rst = 0; out_ready = 1; req_valid = '0; refill();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            model_eval();
            if (i == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ov ov=%b want 0", out_valid); end
            end
            checks++;
            if (req_ready !== exp_ready || out_valid !== m_s2v || out_data !== m_s2d ||
                out_id !== ID_W'(m_s2id) || busy !== exp_busy) begin
                errors++;
                $display("FAIL rstmid_model cyc=%0d rdy=%b/%b ov=%b/%b d=%h/%h id=%0d/%0d", cyc,
                         req_ready, exp_ready, out_valid, m_s2v, out_data, m_s2d, out_id, m_s2id);
            end
            for (int k = 0; k < NREQ; k++) if (first < 0 && req_ready[k] && req_valid[k]) first = k;
            adv();
        end
        checks++;
        if (first != 0) begin errors++; $display("FAIL rstmid_ptr first=%0d want 0", first); end
        checks++;
        if (got_q.size() > exp_q.size()) begin errors++; $display("FAIL rstmid_stale got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL rstmid_sb[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            en        = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < NREQ; k++) if (!req_valid[k] && $urandom_range(0, 1) == 1) raise(k);
            @(negedge clk);
            model_eval();
            checks++;
            if (req_ready !== exp_ready || out_valid !== m_s2v || out_data !== m_s2d ||
                out_id !== ID_W'(m_s2id) || busy !== exp_busy) begin
                errors++;
                $display("FAIL rand_model cyc=%0d rdy=%b/%b ov=%b/%b d=%h/%h id=%0d/%0d busy=%b/%b", cyc,
                         req_ready, exp_ready, out_valid, m_s2v, out_data, m_s2d, out_id, m_s2id, busy, exp_busy);
            end
            adv();
        end
        rst = 0;
        checks++;
        if (got_q.size() > exp_q.size()) begin errors++; $display("FAIL rand_sb_size got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            checks++;
            if (got_q[k] != exp_q[k]) begin errors++; $display("FAIL rand_sb[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
